// File: rtl/exp3_gravador_memoria_pkg.sv
// Shared exp3 definitions: default widths and the FSM state codes shown on db_estado.
package exp3_gravador_memoria_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned ESTADO_W   = 4;

    // Encodings double as the debug code driven to the 7-segment display.
    typedef enum logic [ESTADO_W-1:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h3,
        ESCREVE    = 4'h4,
        PROXIMO    = 4'h5,
        FIM        = 4'hF
    } estado_t;

endpackage

// File: rtl/exp3_detector_borda.sv
// Rising-edge detector for the synchronous record button.
// Ports: clock, reset (async active-low), sinal (level in), pulso_c (one-cycle pulse, combinational
// from sinal and its registered history).
module exp3_detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso_c
);

    logic sinal_d;

    // One-cycle history of the button level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinal_d <= 1'b0;
        end else begin
            sinal_d <= sinal;
        end
    end

    assign pulso_c = sinal & ~sinal_d;

endmodule

// File: rtl/exp3_gravador_memoria.sv
// Writer side of the exp3 sequential memory: records one 4-bit word per button press into
// consecutive addresses of the shared 16x4 RAM, then reports completion.
// Ports: clock, reset (async active-low), iniciar (start run), gravar (record button level),
// chaves (word to record); mem_we/mem_addr/mem_dado drive the RAM write port; pronto flags a
// finished run; db_contagem/db_estado are debug copies of the counter and state code.
module exp3_gravador_memoria
    import exp3_gravador_memoria_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                gravar,
    input  logic [DATA_W-1:0]   chaves,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_dado,
    output logic                pronto,
    output logic [ADDR_W-1:0]   db_contagem,
    output logic [ESTADO_W-1:0] db_estado
);

    // DEPTH = 2**ADDR_W, so the last address is all ones.
    localparam logic [ADDR_W-1:0] ULTIMO = {ADDR_W{1'b1}};

    estado_t             estado;
    estado_t             estado_prox;
    logic [ADDR_W-1:0]   contagem;
    logic [DATA_W-1:0]   dado;
    logic                pulso_c;
    logic                limpa_c;
    logic                incrementa_c;
    logic                carrega_c;

    exp3_detector_borda u_detector (
        .clock   (clock),
        .reset   (reset),
        .sinal   (gravar),
        .pulso_c (pulso_c)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        estado_prox  = estado;
        limpa_c      = 1'b0;
        incrementa_c = 1'b0;
        carrega_c    = 1'b0;
        case (estado)
            INICIAL:    if (iniciar) estado_prox = PREPARACAO;
            PREPARACAO: begin
                limpa_c     = 1'b1;
                estado_prox = ESPERA;
            end
            ESPERA:     if (pulso_c) estado_prox = REGISTRA;
            REGISTRA:   begin
                carrega_c   = 1'b1;
                estado_prox = ESCREVE;
            end
            ESCREVE:    estado_prox = (contagem == ULTIMO) ? FIM : PROXIMO;
            PROXIMO:    begin
                incrementa_c = 1'b1;
                estado_prox  = ESPERA;
            end
            FIM:        if (iniciar) estado_prox = PREPARACAO;
            default:    estado_prox = INICIAL;
        endcase
    end

    // Address counter and data register; the counter only advances in proximo, so it never wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
            dado     <= '0;
        end else begin
            if (limpa_c) begin
                contagem <= '0;
                dado     <= '0;
            end else begin
                if (incrementa_c) contagem <= contagem + ADDR_W'(1);
                if (carrega_c)    dado     <= chaves;
            end
        end
    end

    // Moore flags registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_we <= 1'b0;
            pronto <= 1'b0;
        end else begin
            mem_we <= (estado_prox == ESCREVE);
            pronto <= (estado_prox == FIM);
        end
    end

    assign mem_addr    = contagem;
    assign mem_dado    = dado;
    assign db_contagem = contagem;
    assign db_estado   = estado;

endmodule

// File: tb/tb_exp3_gravador_memoria.sv
// Directed bench for the exp3 memory writer.
module tb_exp3_gravador_memoria;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       gravar;
    logic [3:0] chaves;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [3:0] mem_dado;
    logic       pronto;
    logic [3:0] db_contagem;
    logic [3:0] db_estado;

    int checks;
    int errors;
    int wr_count;
    logic [3:0] last_addr;
    logic [3:0] last_dado;

    exp3_gravador_memoria dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .gravar      (gravar),
        .chaves      (chaves),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_dado    (mem_dado),
        .pronto      (pronto),
        .db_contagem (db_contagem),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Models the RAM write port: a word is stored on each rising edge with mem_we high.
    always @(posedge clock) begin
        if (reset && mem_we) begin
            wr_count  <= wr_count + 1;
            last_addr <= mem_addr;
            last_dado <= mem_dado;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One press from espera; returns to espera unless it is the last word of the run.
    task automatic press(input logic [3:0] valor, input logic [3:0] addr_esp, input bit ultimo);
        chaves = valor;
        gravar = 1'b1;
        tick();
        gravar = 1'b0;
        check("estado_registra", 8'(db_estado), 8'h3);
        tick();
        check("we_escreve", 8'(mem_we), 8'h1);
        check("addr_escreve", 8'(mem_addr), 8'(addr_esp));
        check("dado_escreve", 8'(mem_dado), 8'(valor));
        tick();
        check("we_pulso_unico", 8'(mem_we), 8'h0);
        if (!ultimo) tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_count = 0;
        last_addr = 4'h0;
        last_dado = 4'h0;
        reset   = 1'b0;
        iniciar = 1'b0;
        gravar  = 1'b0;
        chaves  = 4'h0;
        tick();
        tick();
        check("rst_estado", 8'(db_estado), 8'h0);
        check("rst_we", 8'(mem_we), 8'h0);
        check("rst_pronto", 8'(pronto), 8'h0);
        check("rst_addr", 8'(mem_addr), 8'h0);
        check("rst_dado", 8'(mem_dado), 8'h0);
        reset = 1'b1;
        tick();
        check("idle_sem_iniciar", 8'(db_estado), 8'h0);

        // Start a run.
        iniciar = 1'b1;
        tick();
        check("preparacao", 8'(db_estado), 8'h1);
        iniciar = 1'b0;
        tick();
        check("espera", 8'(db_estado), 8'h2);
        check("contagem_0", 8'(db_contagem), 8'h0);

        // Held button: exactly one write.
        chaves = 4'hA;
        gravar = 1'b1;
        repeat (20) tick();
        gravar = 1'b0;
        tick();
        check("held_writes", 8'(wr_count), 8'd1);
        check("held_addr", 8'(last_addr), 8'h0);
        check("held_dado", 8'(last_dado), 8'hA);
        check("held_estado", 8'(db_estado), 8'h2);
        check("held_contagem", 8'(db_contagem), 8'h1);

        // chaves changes after registra exits: stored word keeps the earlier value.
        chaves = 4'h3;
        gravar = 1'b1;
        tick();
        gravar = 1'b0;
        tick();
        chaves = 4'h7;
        check("late_we", 8'(mem_we), 8'h1);
        check("late_addr", 8'(mem_addr), 8'h1);
        #3;
        check("late_dado", 8'(mem_dado), 8'h3);
        tick();
        tick();
        check("late_stored", 8'(last_dado), 8'h3);
        check("late_contagem", 8'(db_contagem), 8'h2);

        // A press during proximo is discarded.
        chaves = 4'h5;
        gravar = 1'b1;
        tick();
        gravar = 1'b0;
        tick();
        tick();
        check("proximo_estado", 8'(db_estado), 8'h5);
        gravar = 1'b1;
        tick();
        repeat (3) tick();
        check("ign_estado", 8'(db_estado), 8'h2);
        check("ign_writes", 8'(wr_count), 8'd3);
        check("ign_contagem", 8'(db_contagem), 8'h3);
        gravar = 1'b0;
        tick();

        // Reset asserted during escreve.
        chaves = 4'h6;
        gravar = 1'b1;
        tick();
        gravar = 1'b0;
        tick();
        check("pre_rst_estado", 8'(db_estado), 8'h4);
        reset = 1'b0;
        #1;
        check("midrst_we", 8'(mem_we), 8'h0);
        check("midrst_pronto", 8'(pronto), 8'h0);
        check("midrst_estado", 8'(db_estado), 8'h0);
        check("midrst_contagem", 8'(db_contagem), 8'h0);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_writes", 8'(wr_count), 8'd3);
        check("midrst_idle", 8'(db_estado), 8'h0);

        // Full run of 16 words, data k at address k.
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) begin
            press(4'(k), 4'(k), k == 15);
        end
        check("run_pronto", 8'(pronto), 8'h1);
        check("run_estado", 8'(db_estado), 8'hF);
        check("run_writes", 8'(wr_count), 8'd19);
        check("run_last_addr", 8'(last_addr), 8'hF);
        check("run_contagem", 8'(db_contagem), 8'hF);
        tick();
        check("pronto_mantido", 8'(pronto), 8'h1);

        // New run from fim.
        iniciar = 1'b1;
        tick();
        check("novo_estado", 8'(db_estado), 8'h1);
        check("novo_pronto", 8'(pronto), 8'h0);
        iniciar = 1'b0;
        tick();
        check("novo_contagem", 8'(db_contagem), 8'h0);
        check("novo_espera", 8'(db_estado), 8'h2);
        press(4'h9, 4'h0, 1'b0);
        check("novo_contagem_1", 8'(db_contagem), 8'h1);
        check("novo_writes", 8'(wr_count), 8'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
